lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 41 ++++
 rtl/lsu.sv | 136 +++++++++++++
 tb/tb_lsu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request/response and RAM-port bundle between a core-side master and the LSU.
// The LSU uses the slave modport; the requester/RAM side uses master.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_lsu_req_valid;
  logic                  o_lsu_req_ready;
  logic                  i_lsu_req_wr;
  logic [1:0]            i_lsu_req_size;
  logic                  i_lsu_req_unsigned;
  logic [ADDR_WIDTH-1:0] i_lsu_req_addr;
  logic [DATA_WIDTH-1:0] i_lsu_req_data;
  logic                  o_lsu_rsp_valid;
  logic                  i_lsu_rsp_ready;
  logic [DATA_WIDTH-1:0] o_lsu_rsp_data;
  logic                  o_lsu_rsp_err;
  logic                  o_ram_rd_en;
  logic [ADDR_WIDTH-1:0] o_ram_rd_addr;
  logic [DATA_WIDTH-1:0] i_ram_rd_data;
  logic                  o_ram_wr_en;
  logic [ADDR_WIDTH-1:0] o_ram_wr_addr;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic [3:0]            o_ram_wr_mask;

  modport slave (
    input  i_lsu_req_valid, i_lsu_req_wr, i_lsu_req_size, i_lsu_req_unsigned,
    input  i_lsu_req_addr, i_lsu_req_data, i_lsu_rsp_ready, i_ram_rd_data,
    output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data, o_lsu_rsp_err,
    output o_ram_rd_en, o_ram_rd_addr, o_ram_wr_en, o_ram_wr_addr,
    output o_ram_wr_data, o_ram_wr_mask
  );

  modport master (
    output i_lsu_req_valid, i_lsu_req_wr, i_lsu_req_size, i_lsu_req_unsigned,
    output i_lsu_req_addr, i_lsu_req_data, i_lsu_rsp_ready, i_ram_rd_data,
    input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data, o_lsu_rsp_err,
    input  o_ram_rd_en, o_ram_rd_addr, o_ram_wr_en, o_ram_wr_addr,
    input  o_ram_wr_data, o_ram_wr_mask
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: IDLE -> EXEC -> RESP. Loads extract and extend
// a lane of the RAM word; stores pass data unshifted with a size mask. DATA_WIDTH must be 32.
module lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic  i_sys_clk,
  input logic  i_sys_rst,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic                  wr_reg;
  logic [1:0]            size_reg;
  logic                  unsigned_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic                  rsp_err_reg;

  logic                  req_ready, rsp_valid, exec_rd, exec_wr;
  logic                  accept, misaligned;
  logic [7:0]            rd_bytes [4];
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            wr_mask;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_bytes[gi] = bus.i_ram_rd_data[8*gi +: 8];
    end
  endgenerate

  assign misaligned = (bus.i_lsu_req_size == 2'd3) ||
                      (bus.i_lsu_req_size == 2'd1 && bus.i_lsu_req_addr[0]) ||
                      (bus.i_lsu_req_size == 2'd2 && bus.i_lsu_req_addr[1:0] != 2'b00);
  assign accept     = req_ready && bus.i_lsu_req_valid;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  // Reset overrides every output combinationally, so a store caught in EXEC never writes.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    exec_rd    = 1'b0;
    exec_wr    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.i_lsu_req_valid) state_next = misaligned ? RESP : EXEC;
      end
      EXEC: begin
        exec_rd    = 1'b1;
        exec_wr    = wr_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.i_lsu_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (i_sys_rst) begin
      state_next = IDLE;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      exec_rd    = 1'b0;
      exec_wr    = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_reg       <= 1'b0;
      size_reg     <= 2'd0;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        wr_reg       <= bus.i_lsu_req_wr;
        size_reg     <= bus.i_lsu_req_size;
        unsigned_reg <= bus.i_lsu_req_unsigned;
        addr_reg     <= bus.i_lsu_req_addr;
        data_reg     <= bus.i_lsu_req_data;
        rsp_data_reg <= '0;
        rsp_err_reg  <= misaligned;
      end
      if (state_reg == EXEC) rsp_data_reg <= wr_reg ? '0 : load_ext;
    end
  end

  assign byte_sel = rd_bytes[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? {rd_bytes[3], rd_bytes[2]} : {rd_bytes[1], rd_bytes[0]};

  always_comb begin
    load_ext = bus.i_ram_rd_data;
    case (size_reg)
      2'd0: load_ext = unsigned_reg ? {{(DATA_WIDTH-8){1'b0}}, byte_sel}
                                    : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      2'd1: load_ext = unsigned_reg ? {{(DATA_WIDTH-16){1'b0}}, half_sel}
                                    : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      default: load_ext = bus.i_ram_rd_data;
    endcase
  end

  always_comb begin
    wr_mask = 4'b0000;
    case (size_reg)
      2'd0:    wr_mask = 4'b0001;
      2'd1:    wr_mask = 4'b0011;
      2'd2:    wr_mask = 4'b1111;
      default: wr_mask = 4'b0000;
    endcase
  end

  assign bus.o_lsu_req_ready = req_ready;
  assign bus.o_lsu_rsp_valid = rsp_valid;
  assign bus.o_lsu_rsp_data  = rsp_valid ? rsp_data_reg : '0;
  assign bus.o_lsu_rsp_err   = rsp_valid ? rsp_err_reg : 1'b0;
  assign bus.o_ram_rd_en     = exec_rd;
  assign bus.o_ram_rd_addr   = exec_rd ? addr_reg : '0;
  assign bus.o_ram_wr_en     = exec_wr;
  assign bus.o_ram_wr_addr   = exec_wr ? addr_reg : '0;
  assign bus.o_ram_wr_data   = exec_wr ? data_reg : '0;
  assign bus.o_ram_wr_mask   = exec_wr ? wr_mask : 4'b0000;
endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: a word RAM serves the DUT, a byte-array model predicts
// every response, RAM enable activity is counted per transaction.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int ram_en_cnt = 0;
  int txn_no = 0;

  logic [31:0] ram_mem  [256];
  logic [31:0] init_mem [256];
  logic        init_pulse = 1'b0;
  logic [7:0]  ref_mem  [1024];

  assign bus.i_ram_rd_data = ram_mem[bus.o_ram_rd_addr[9:2]];

  // RAM merges sub-word stores: lane i of wr_data lands at byte addr[1:0]+i.
  always @(posedge clk) begin
    if (init_pulse) begin
      for (int w = 0; w < 256; w++) ram_mem[w] <= init_mem[w];
    end else if (bus.o_ram_wr_en) begin
      for (int i = 0; i < 4; i++)
        if (bus.o_ram_wr_mask[i] && (i + int'(bus.o_ram_wr_addr[1:0])) < 4)
          ram_mem[bus.o_ram_wr_addr[9:2]][8*(i+int'(bus.o_ram_wr_addr[1:0])) +: 8]
            <= bus.o_ram_wr_data[8*i +: 8];
    end
    if (bus.o_ram_rd_en || bus.o_ram_wr_en) ram_en_cnt <= ram_en_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic u, input logic [31:0] a);
    int n = nbytes(s);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic do_txn(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data, input int hold,
                        output logic [31:0] obs_data);
    logic        exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    int          en_before;
    exp_err  = model_err(size, addr);
    exp_data = (exp_err || wr) ? 32'h0 : model_load(size, uns, addr);
    exp_mask = (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111;
    @(negedge clk);
    bus.i_lsu_req_valid    = 1'b1;
    bus.i_lsu_req_wr       = wr;
    bus.i_lsu_req_size     = size;
    bus.i_lsu_req_unsigned = uns;
    bus.i_lsu_req_addr     = addr;
    bus.i_lsu_req_data     = data;
    check_eq("req_ready_idle", 32'(bus.o_lsu_req_ready), 32'd1);
    en_before = ram_en_cnt;
    @(posedge clk); #1;
    bus.i_lsu_req_valid = 1'b0;
    if (!exp_err) begin
      check_eq("rsp_valid_exec", 32'(bus.o_lsu_rsp_valid), 32'd0);
      check_eq("ram_rd_en", 32'(bus.o_ram_rd_en), 32'd1);
      check_eq("ram_wr_en", 32'(bus.o_ram_wr_en), 32'(wr));
      check_eq("ram_rd_addr", bus.o_ram_rd_addr, addr);
      if (wr) begin
        check_eq("ram_wr_addr", bus.o_ram_wr_addr, addr);
        check_eq("ram_wr_mask", 32'(bus.o_ram_wr_mask), 32'(exp_mask));
        check_eq("ram_wr_data", bus.o_ram_wr_data, data);
      end
      @(posedge clk); #1;
    end
    obs_data = bus.o_lsu_rsp_data;
    for (int c = 0; c <= hold; c++) begin
      check_eq("rsp_valid", 32'(bus.o_lsu_rsp_valid), 32'd1);
      check_eq("rsp_data", bus.o_lsu_rsp_data, exp_data);
      check_eq("rsp_err", 32'(bus.o_lsu_rsp_err), 32'(exp_err));
      check_eq("req_ready_busy", 32'(bus.o_lsu_req_ready), 32'd0);
      if (c == hold) bus.i_lsu_rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.i_lsu_rsp_ready = 1'b0;
    check_eq("rsp_valid_after", 32'(bus.o_lsu_rsp_valid), 32'd0);
    check_eq("req_ready_after", 32'(bus.o_lsu_req_ready), 32'd1);
    check_eq("ram_en_cycles", 32'(ram_en_cnt - en_before), exp_err ? 32'd0 : 32'd1);
    if (wr && !exp_err)
      for (int i = 0; i < nbytes(size); i++) ref_mem[addr + i] = data[8*i +: 8];
    txn_no++;
    $display("txn %0d wr=%0d size=%0d uns=%0d addr=%h data=%h hold=%0d -> rsp=%h err=%0d",
             txn_no, wr, size, uns, addr, data, hold, obs_data, exp_err);
  endtask

  logic [31:0] got;

  initial begin
    bus.i_lsu_req_valid    = 1'b0;
    bus.i_lsu_req_wr       = 1'b0;
    bus.i_lsu_req_size     = 2'd0;
    bus.i_lsu_req_unsigned = 1'b0;
    bus.i_lsu_req_addr     = 32'h0;
    bus.i_lsu_req_data     = 32'h0;
    bus.i_lsu_rsp_ready    = 1'b0;
    for (int w = 0; w < 256; w++) begin
      init_mem[w] = (w == 64) ? 32'h8899AABB : $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_mem[w][8*b +: 8];
    end
    init_pulse = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    init_pulse = 1'b0;
    check_eq("rst_req_ready", 32'(bus.o_lsu_req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.o_lsu_rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.o_lsu_rsp_data, 32'h0);
    check_eq("rst_ram_en", {30'd0, bus.o_ram_rd_en, bus.o_ram_wr_en}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, got);
    check_eq("ld_byte_s_101", got, 32'hFFFFFFAA);
    do_txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1, got);
    check_eq("ld_half_u_102", got, 32'h00008899);
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, got);
    check_eq("ld_word_100", got, 32'h8899AABB);
    do_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000005A, 0, got);
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, got);
    check_eq("ld_word_after_st", got, 32'h5A99AABB);
    do_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, got);
    do_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 3, got);
    do_txn(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 3, got);

    // Reset lands in the EXEC cycle of a store: no write, nothing pending afterwards.
    @(negedge clk);
    bus.i_lsu_req_valid = 1'b1; bus.i_lsu_req_wr = 1'b1; bus.i_lsu_req_size = 2'd2;
    bus.i_lsu_req_addr = 32'h200; bus.i_lsu_req_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.i_lsu_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_exec_wr_en", 32'(bus.o_ram_wr_en), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_exec_req_ready", 32'(bus.o_lsu_req_ready), 32'd0);
    check_eq("rst_exec_rsp_valid", 32'(bus.o_lsu_rsp_valid), 32'd0);
    check_eq("rst_exec_ram", ram_mem[128], ref_word(32'h200));
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_exec_idle", 32'(bus.o_lsu_req_ready), 32'd1);

    // Reset while a response waits: it is dropped without a handshake.
    @(negedge clk);
    bus.i_lsu_req_valid = 1'b1; bus.i_lsu_req_wr = 1'b0; bus.i_lsu_req_size = 2'd2;
    bus.i_lsu_req_addr = 32'h100;
    @(posedge clk); #1;
    bus.i_lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("resp_before_rst", 32'(bus.o_lsu_rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_resp_valid", 32'(bus.o_lsu_rsp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_resp_idle", 32'(bus.o_lsu_req_ready), 32'd1);
    check_eq("rst_resp_valid2", 32'(bus.o_lsu_rsp_valid), 32'd0);

    for (int t = 0; t < 150; t++) begin
      logic [1:0]  s;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 7);
      s = (r == 7) ? 2'd3 : 2'(r % 3);
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      do_txn(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), got);
    end

    for (int w = 64; w < 72; w++)
      check_eq("ram_final", ram_mem[w], ref_word(32'(4 * w)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
